// File: rtl/oled_region_scheduler.sv
// Debounces three slide switches into a display mode, latches the mode at frame
// boundaries (optionally rotating through regions) and paints the active third of the OLED.
module oled_region_scheduler #(
    parameter int          DEBOUNCE_CYCLES = 200000,
    parameter int          ROTATE_FRAMES   = 60,
    parameter logic [15:0] COLOR           = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SW1,
    input  logic        SW2,
    input  logic        SW3,
    input  logic        frame_begin,
    input  logic [6:0]  x,
    output logic [15:0] pixel_data,
    output logic [1:0]  active_region,
    output logic        rotating,
    output logic        mode_change
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int FW = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(ROTATE_FRAMES - 1);

    logic [2:0]    sw_raw;
    logic [2:0]    meta_q, sync_q;
    logic [2:0]    deb_q, deb_d;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];

    logic [1:0]    region_q, region_d;
    logic          rot_q, rot_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          mc_q, mc_d;
    logic [15:0]   pix_q, pix_d;

    logic          req_rot;
    logic [1:0]    req_region;
    logic          in_region;

    assign sw_raw = {SW3, SW2, SW1};

    // A switch flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_rot    = &deb_q;
        req_region = 2'd0;
        if (deb_q[0])      req_region = 2'd1;
        else if (deb_q[1]) req_region = 2'd2;
        else if (deb_q[2]) req_region = 2'd3;

        region_d = region_q;
        rot_d    = rot_q;
        fcnt_d   = fcnt_q;
        if (frame_begin) begin
            if (req_rot) begin
                rot_d = 1'b1;
                if (!rot_q) begin
                    region_d = 2'd1;
                    fcnt_d   = '0;
                end else if (fcnt_q == FR_LAST) begin
                    fcnt_d   = '0;
                    region_d = (region_q == 2'd3) ? 2'd1 : region_q + 2'd1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end else begin
                rot_d    = 1'b0;
                region_d = req_region;
                fcnt_d   = '0;
            end
        end
        mc_d = (region_d != region_q) || (rot_d != rot_q);
    end

    // Pixel colour follows the region already latched, one cycle behind x.
    always_comb begin
        case (region_q)
            2'd1:    in_region = (x < 7'd32);
            2'd2:    in_region = (x >= 7'd32) && (x < 7'd64);
            2'd3:    in_region = (x >= 7'd64) && (x < 7'd96);
            default: in_region = 1'b0;
        endcase
        pix_d = in_region ? COLOR : 16'h0000;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q   <= '0;
            sync_q   <= '0;
            deb_q    <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            region_q <= 2'd0;
            rot_q    <= 1'b0;
            fcnt_q   <= '0;
            mc_q     <= 1'b0;
            pix_q    <= 16'h0000;
        end else begin
            meta_q   <= sw_raw;
            sync_q   <= meta_q;
            deb_q    <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            region_q <= region_d;
            rot_q    <= rot_d;
            fcnt_q   <= fcnt_d;
            mc_q     <= mc_d;
            pix_q    <= pix_d;
        end
    end

    assign pixel_data    = pix_q;
    assign active_region = region_q;
    assign rotating      = rot_q;
    assign mode_change   = mc_q;
endmodule
